// File: rtl/l1d_data_pipe_arb.sv
// L1D data-RAM arbiter: write/read arbitration with a starvation guard, a registered
// single-port RAM command, and a credit-guarded read-response FIFO. Optional perf counters: L1D_DATA_ARB_PERF_EN.
module l1d_data_pipe_arb #(
    parameter int INDEX_W    = 6,
    parameter int OFFSET_W   = 2,
    parameter int WAY_W      = 2,
    parameter int DATA_W     = 128,
    parameter int ID_W       = 4,
    parameter int RD_LAT     = 2,
    parameter int RSP_DEPTH  = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr_req_dat_vld,
    output logic                                 wr_req_dat_rdy,
    input  logic [INDEX_W+OFFSET_W+WAY_W-1:0]    wr_req_addr,
    input  logic [DATA_W-1:0]                    wr_req_dat,
    input  logic [DATA_W/8-1:0]                  wr_req_dat_be,
    input  logic                                 rd_req_vld,
    output logic                                 rd_req_rdy,
    input  logic [INDEX_W+OFFSET_W+WAY_W-1:0]    rd_req_addr,
    input  logic [ID_W-1:0]                      rd_req_id,
    output logic                                 ram_en,
    output logic                                 ram_we,
    output logic [INDEX_W+OFFSET_W+WAY_W-1:0]    ram_addr,
    output logic [DATA_W-1:0]                    ram_wdata,
    output logic [DATA_W/8-1:0]                  ram_be,
    input  logic [DATA_W-1:0]                    ram_rdata,
    output logic                                 rd_rsp_vld,
    input  logic                                 rd_rsp_rdy,
    output logic [ID_W-1:0]                      rd_rsp_id,
    output logic [DATA_W-1:0]                    rd_rsp_dat
`ifdef L1D_DATA_ARB_PERF_EN
    ,
    output logic [31:0]                          perf_wr_cnt,
    output logic [31:0]                          perf_rd_cnt,
    output logic [31:0]                          perf_starve_cnt
`endif
);

    localparam int ADDR_W = INDEX_W + OFFSET_W + WAY_W;
    localparam int BE_W   = DATA_W / 8;
    localparam int CRD_W  = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int STV_W  = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] dat;
    } rsp_t;

    logic [CRD_W-1:0] credit;
    logic [STV_W-1:0] starve_cnt;
    logic             credit_ok;
    logic             starved;
    logic             rd_gnt;
    logic             wr_gnt;
    logic             push;
    logic             pop;

    // ---------------- arbitration ----------------
    assign credit_ok      = (credit != '0);
    assign starved        = (starve_cnt == STV_W'(STARVE_MAX));
    // Read rdy is independent of rd_req_vld; write only loses when a read actually wins.
    assign rd_req_rdy     = credit_ok && (!wr_req_dat_vld || starved);
    assign rd_gnt         = rd_req_vld && rd_req_rdy;
    assign wr_req_dat_rdy = !rd_gnt;
    assign wr_gnt         = wr_req_dat_vld && wr_req_dat_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_be    <= '0;
        end else begin
            ram_en <= wr_gnt || rd_gnt;
            ram_we <= wr_gnt;
            if (wr_gnt) begin
                ram_addr  <= wr_req_addr;
                ram_wdata <= wr_req_dat;
                ram_be    <= wr_req_dat_be;
            end else if (rd_gnt) begin
                ram_addr  <= rd_req_addr;
            end
        end
    end

    // Counts consecutive losses of an eligible read; frozen while out of credit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            starve_cnt <= '0;
        else if (!rd_req_vld || rd_gnt)
            starve_cnt <= '0;
        else if (credit_ok && wr_gnt && !starved)
            starve_cnt <= starve_cnt + 1'b1;
    end

    // ---------------- read tag pipe ----------------
    // Stage RD_LAT lines up with ram_rdata for the read issued RD_LAT cycles earlier.
    logic [RD_LAT:0]           vld_pipe;
    logic [RD_LAT:0][ID_W-1:0] id_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[RD_LAT-1:0], rd_gnt};
            id_pipe  <= {id_pipe[RD_LAT-1:0], rd_req_id};
        end
    end

    // ---------------- response FIFO ----------------
    rsp_t             fifo [RSP_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CRD_W-1:0] count;

    assign push       = vld_pipe[RD_LAT];
    assign rd_rsp_vld = (count != '0);
    assign pop        = rd_rsp_vld && rd_rsp_rdy;
    assign rd_rsp_id  = fifo[rd_ptr].id;
    assign rd_rsp_dat = fifo[rd_ptr].dat;

    always_ff @(posedge clk) begin
        if (push)
            fifo[wr_ptr] <= '{id: id_pipe[RD_LAT], dat: ram_rdata};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            credit <= CRD_W'(RSP_DEPTH);
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count  <= count + CRD_W'(push) - CRD_W'(pop);
            // Credit is reserved at grant so the FIFO can never overflow.
            credit <= credit - CRD_W'(rd_gnt) + CRD_W'(pop);
        end
    end

`ifdef L1D_DATA_ARB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_wr_cnt     <= '0;
            perf_rd_cnt     <= '0;
            perf_starve_cnt <= '0;
        end else begin
            if (wr_gnt)
                perf_wr_cnt <= perf_wr_cnt + 32'd1;
            if (rd_gnt)
                perf_rd_cnt <= perf_rd_cnt + 32'd1;
            if (rd_gnt && wr_req_dat_vld)
                perf_starve_cnt <= perf_starve_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_l1d_data_pipe_arb.sv
// Bench for l1d_data_pipe_arb: RAM model plus a response scoreboard filled at read handshake.
module tb_l1d_data_pipe_arb;
    localparam int INDEX_W = 6, OFFSET_W = 2, WAY_W = 2, DATA_W = 128, ID_W = 4;
    localparam int RD_LAT = 2, RSP_DEPTH = 4, STARVE_MAX = 4;
    localparam int ADDR_W = INDEX_W + OFFSET_W + WAY_W;
    localparam int BE_W = DATA_W / 8;

    logic              clk, rst;
    logic              wr_req_dat_vld, wr_req_dat_rdy;
    logic [ADDR_W-1:0] wr_req_addr;
    logic [DATA_W-1:0] wr_req_dat;
    logic [BE_W-1:0]   wr_req_dat_be;
    logic              rd_req_vld, rd_req_rdy;
    logic [ADDR_W-1:0] rd_req_addr;
    logic [ID_W-1:0]   rd_req_id;
    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [BE_W-1:0]   ram_be;
    logic [DATA_W-1:0] ram_rdata;
    logic              rd_rsp_vld, rd_rsp_rdy;
    logic [ID_W-1:0]   rd_rsp_id;
    logic [DATA_W-1:0] rd_rsp_dat;

    l1d_data_pipe_arb #(
        .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .WAY_W(WAY_W), .DATA_W(DATA_W), .ID_W(ID_W),
        .RD_LAT(RD_LAT), .RSP_DEPTH(RSP_DEPTH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_req_dat_vld(wr_req_dat_vld), .wr_req_dat_rdy(wr_req_dat_rdy),
        .wr_req_addr(wr_req_addr), .wr_req_dat(wr_req_dat), .wr_req_dat_be(wr_req_dat_be),
        .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy),
        .rd_req_addr(rd_req_addr), .rd_req_id(rd_req_id),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_rdata(ram_rdata),
        .rd_rsp_vld(rd_rsp_vld), .rd_rsp_rdy(rd_rsp_rdy),
        .rd_rsp_id(rd_rsp_id), .rd_rsp_dat(rd_rsp_dat)
    );

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] dat;
    } exp_t;

    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb[$];
    logic [DATA_W-1:0] mem [1<<ADDR_W];
    logic [DATA_W-1:0] rpipe [RD_LAT];
    logic [DATA_W-1:0] wm;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: byte-enabled write, read data RD_LAT cycles after the read command.
    assign ram_rdata = rpipe[RD_LAT-1];
    always @(posedge clk) begin
        if (ram_en && ram_we) begin
            wm = mem[ram_addr];
            for (int b = 0; b < BE_W; b++)
                if (ram_be[b]) wm[b*8 +: 8] = ram_wdata[b*8 +: 8];
            mem[ram_addr] <= wm;
        end
        rpipe[0] <= (ram_en && !ram_we) ? mem[ram_addr] : '0;
        for (int k = 1; k < RD_LAT; k++) rpipe[k] <= rpipe[k-1];
    end

    // Scoreboard: expectation captured at read handshake, compared at response pop.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            if (rd_rsp_vld && rd_rsp_rdy) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected: got id=%0h dat=%0h, required no response", rd_rsp_id, rd_rsp_dat);
                end else begin
                    e = sb.pop_front();
                    if (rd_rsp_id !== e.id || rd_rsp_dat !== e.dat) begin
                        n_fail++;
                        $display("FAIL rsp_data: got id=%0h dat=%0h, required id=%0h dat=%0h",
                                 rd_rsp_id, rd_rsp_dat, e.id, e.dat);
                    end
                end
            end
            if (rd_req_vld && rd_req_rdy) begin
                e.id  = rd_req_id;
                e.dat = mem[rd_req_addr];
                if (ram_en && ram_we && ram_addr == rd_req_addr)
                    for (int b = 0; b < BE_W; b++)
                        if (ram_be[b]) e.dat[b*8 +: 8] = ram_wdata[b*8 +: 8];
                sb.push_back(e);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        rd_rsp_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !rd_rsp_vld) break;
        end
        cyc();
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({ram_en, ram_we, rd_rsp_vld} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes: got %b, required 000", {ram_en, ram_we, rd_rsp_vld});
        end
        n_cmp++;
        if (ram_addr !== '0 || ram_wdata !== '0 || ram_be !== '0) begin
            n_fail++; $display("FAIL reset_cmd: got addr=%0h wdata=%0h be=%0h, required 0", ram_addr, ram_wdata, ram_be);
        end
        n_cmp++;
        if ({rd_req_rdy, wr_req_dat_rdy} !== 2'b11) begin
            n_fail++; $display("FAIL reset_rdy: got %b, required 11", {rd_req_rdy, wr_req_dat_rdy});
        end
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_write();
        cyc();
        wr_req_dat_vld = 1'b1;
        wr_req_addr    = 10'h2A5;
        wr_req_dat     = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        wr_req_dat_be  = '1;
        @(negedge clk);
        n_cmp++;
        if (wr_req_dat_rdy !== 1'b1 || ram_en !== 1'b0) begin
            n_fail++; $display("FAIL wr_accept: got rdy=%b en=%b, required rdy=1 en=0", wr_req_dat_rdy, ram_en);
        end
        cyc();
        wr_req_dat_vld = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ram_en, ram_we} !== 2'b11 || ram_addr !== 10'h2A5) begin
            n_fail++; $display("FAIL wr_cmd: got en/we=%b addr=%0h, required 11 addr=2a5", {ram_en, ram_we}, ram_addr);
        end
        n_cmp++;
        if (ram_wdata !== 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 || ram_be !== 16'hFFFF) begin
            n_fail++; $display("FAIL wr_data: got wdata=%0h be=%0h, required wr data and be=ffff", ram_wdata, ram_be);
        end
        cyc();
        @(negedge clk);
        n_cmp++;
        if (ram_en !== 1'b0 || ram_addr !== 10'h2A5) begin
            n_fail++; $display("FAIL wr_idle_hold: got en=%b addr=%0h, required en=0 addr=2a5", ram_en, ram_addr);
        end
    endtask

    task automatic test_read_latency();
        cyc();
        rd_req_vld = 1'b1; rd_req_addr = 10'h005; rd_req_id = 4'd3;
        @(negedge clk);
        n_cmp++;
        if (rd_req_rdy !== 1'b1) begin
            n_fail++; $display("FAIL rd_accept: got rdy=%b, required 1", rd_req_rdy);
        end
        cyc();
        rd_req_vld = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ram_en, ram_we} !== 2'b10 || ram_addr !== 10'h005 || rd_rsp_vld !== 1'b0) begin
            n_fail++; $display("FAIL rd_cmd: got en/we=%b addr=%0h rsp=%b, required 10 addr=5 rsp=0",
                               {ram_en, ram_we}, ram_addr, rd_rsp_vld);
        end
        for (int k = 2; k < 4; k++) begin
            cyc();
            @(negedge clk);
            n_cmp++;
            if (rd_rsp_vld !== 1'b0) begin
                n_fail++; $display("FAIL rd_early: cycle %0d got rsp_vld=%b, required 0", k, rd_rsp_vld);
            end
        end
        cyc();
        @(negedge clk);
        n_cmp++;
        if (rd_rsp_vld !== 1'b1 || rd_rsp_id !== 4'd3 || rd_rsp_dat !== 128'hDEAD) begin
            n_fail++; $display("FAIL rd_latency: got vld=%b id=%0h dat=%0h, required 1 id=3 dat=dead",
                               rd_rsp_vld, rd_rsp_id, rd_rsp_dat);
        end
        cyc();
    endtask

    task automatic test_starvation();
        logic [4:0] rrdy, wrdy;
        rd_rsp_rdy = 1'b1;
        cyc();
        wr_req_dat_vld = 1'b1; wr_req_addr = 10'h100; wr_req_dat_be = 16'h00FF;
        rd_req_vld = 1'b1; rd_req_addr = 10'h006; rd_req_id = 4'd7;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            rrdy[c] = rd_req_rdy;
            wrdy[c] = wr_req_dat_rdy;
            cyc();
            wr_req_addr = wr_req_addr + 1'b1;
        end
        rd_req_vld = 1'b0;
        n_cmp++;
        if (rrdy !== 5'b10000 || wrdy !== 5'b01111) begin
            n_fail++; $display("FAIL starve_pattern: got rd=%b wr=%b, required rd=10000 wr=01111", rrdy, wrdy);
        end
        @(negedge clk);
        n_cmp++;
        if (wr_req_dat_rdy !== 1'b1) begin
            n_fail++; $display("FAIL starve_resume: got wr_rdy=%b, required 1", wr_req_dat_rdy);
        end
        cyc();
        rd_req_vld = 1'b1; rd_req_id = 4'd8;
        @(negedge clk);
        n_cmp++;
        if (rd_req_rdy !== 1'b0) begin
            n_fail++; $display("FAIL starve_cleared: got rd_rdy=%b, required 0", rd_req_rdy);
        end
        cyc();
        rd_req_vld = 1'b0; wr_req_dat_vld = 1'b0;
        drain();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL starve_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_credit();
        int acc = 0;
        logic [ID_W-1:0] nid = '0;
        rd_rsp_rdy = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cyc();
            rd_req_vld = 1'b1; rd_req_id = nid; rd_req_addr = ADDR_W'(10 + nid);
            @(negedge clk);
            if (rd_req_rdy) begin acc++; nid++; end
        end
        n_cmp++;
        if (acc != 4 || rd_req_rdy !== 1'b0) begin
            n_fail++; $display("FAIL credit_limit: got accepted=%0d rdy=%b, required 4 rdy=0", acc, rd_req_rdy);
        end
        cyc();
        rd_req_id = nid; rd_req_addr = ADDR_W'(10 + nid);
        rd_rsp_rdy = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rd_req_rdy !== 1'b0 || rd_rsp_vld !== 1'b1) begin
            n_fail++; $display("FAIL credit_zero_pop: got rdy=%b rsp_vld=%b, required rdy=0 rsp_vld=1", rd_req_rdy, rd_rsp_vld);
        end
        cyc();
        rd_rsp_rdy = 1'b0;
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rd_req_rdy) begin acc++; nid++; end
            cyc();
            rd_req_id = nid; rd_req_addr = ADDR_W'(10 + nid);
        end
        rd_req_vld = 1'b0;
        n_cmp++;
        if (acc != 1) begin
            n_fail++; $display("FAIL credit_one_back: got accepted=%0d, required 1", acc);
        end
        drain();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL credit_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_pop_grant();
        int acc = 0;
        rd_rsp_rdy = 1'b0;
        for (int c = 0; c < 10 && acc < 3; c++) begin
            cyc();
            rd_req_vld = 1'b1; rd_req_id = ID_W'(9 + acc); rd_req_addr = ADDR_W'(40 + acc);
            @(negedge clk);
            if (rd_req_rdy) acc++;
        end
        cyc();
        rd_req_vld = 1'b0;
        repeat (6) cyc();
        rd_req_vld = 1'b1; rd_req_id = 4'd12; rd_req_addr = 10'd50;
        rd_rsp_rdy = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rd_req_rdy !== 1'b1 || rd_rsp_vld !== 1'b1) begin
            n_fail++; $display("FAIL popgrant_c1: got rdy=%b rsp_vld=%b, required 1 1", rd_req_rdy, rd_rsp_vld);
        end
        cyc();
        rd_rsp_rdy = 1'b0; rd_req_id = 4'd13; rd_req_addr = 10'd51;
        @(negedge clk);
        n_cmp++;
        if (rd_req_rdy !== 1'b1) begin
            n_fail++; $display("FAIL popgrant_keep: got rdy=%b, required 1 (credit stays 1)", rd_req_rdy);
        end
        cyc();
        rd_req_id = 4'd14; rd_req_addr = 10'd52;
        @(negedge clk);
        n_cmp++;
        if (rd_req_rdy !== 1'b0) begin
            n_fail++; $display("FAIL popgrant_exhaust: got rdy=%b, required 0", rd_req_rdy);
        end
        cyc();
        rd_req_vld = 1'b0;
        drain();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL popgrant_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_reset_midflight();
        int acc = 0;
        logic seen = 1'b0;
        rd_rsp_rdy = 1'b1;
        cyc();
        rd_req_vld = 1'b1; rd_req_id = 4'd1; rd_req_addr = 10'd20;
        cyc();
        rd_req_id = 4'd2; rd_req_addr = 10'd21;
        cyc();
        rd_req_vld = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({ram_en, ram_we, rd_rsp_vld} !== 3'b000 || ram_addr !== '0) begin
            n_fail++; $display("FAIL midrst_outputs: got en/we/vld=%b addr=%0h, required 000 addr=0",
                               {ram_en, ram_we, rd_rsp_vld}, ram_addr);
        end
        cyc();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rd_rsp_vld) seen = 1'b1;
            cyc();
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL midrst_stale_rsp: got rsp_vld seen=%b, required 0", seen);
        end
        rd_rsp_rdy = 1'b0;
        for (int c = 0; c < 6; c++) begin
            rd_req_vld = 1'b1; rd_req_id = ID_W'(c); rd_req_addr = ADDR_W'(60 + c);
            @(negedge clk);
            if (rd_req_rdy) acc++;
            cyc();
        end
        rd_req_vld = 1'b0;
        n_cmp++;
        if (acc != RSP_DEPTH) begin
            n_fail++; $display("FAIL midrst_credit: got accepted=%0d, required %0d", acc, RSP_DEPTH);
        end
        drain();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL midrst_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    initial begin
        logic [31:0] w;
        rst = 1'b1;
        wr_req_dat_vld = 1'b0; wr_req_addr = '0; wr_req_dat = '0; wr_req_dat_be = '0;
        rd_req_vld = 1'b0; rd_req_addr = '0; rd_req_id = '0;
        rd_rsp_rdy = 1'b1;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            w = 32'(i) * 32'h9E37_79B1 ^ 32'h5A5A_0000;
            mem[i] = {w, ~w, w + 32'd1, w ^ 32'hFFFF_0000};
        end
        mem[5] = 128'hDEAD;
        repeat (2) @(posedge clk);
        test_reset();
        test_write();
        test_read_latency();
        test_starvation();
        test_credit();
        test_pop_grant();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
